or_alu: RTL and testbench
=========================

OR_ALU -- requirements
Module: or_alu

Interface
REQ-001 Parameter: WIDTH, default 32, operand and result width in bits.
REQ-002 Port: clk  input  1  rising-edge clock; the single clock domain.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: a  input  WIDTH  operand A.
REQ-005 Port: b  input  WIDTH  operand B.
REQ-006 Port: s  output  WIDTH  registered result, a OR b.
REQ-007 Port: eq  output  1  registered equality flag, 1 when a == b.
REQ-008 Port: cary  output  1  registered carry flag, 0 for the logical OR operation.
REQ-009 Port: of  output  1  registered overflow flag, 0 for the logical OR operation.

Function
REQ-010 On each rising clk edge with reset low, s SHALL load the bitwise OR of a and b sampled at that edge.
REQ-011 On the same edge, eq SHALL load 1 if all WIDTH bits of a equal b, else 0.
REQ-012 cary and of SHALL load 0 on every edge; they exist for port compatibility with sibling ALU units.
REQ-013 Latency SHALL be exactly one clock cycle from operand sample to output; there is no handshake and no stall.
REQ-014 Operands SHALL be accepted every cycle; back-to-back changes produce back-to-back results with no bubbles.
REQ-015 All outputs SHALL be driven only from flops; there is no combinational input-to-output path.
REQ-016 Boundary: a=b=0 SHALL give s=0 and eq=1; a=b=all-ones SHALL give s=all-ones and eq=1.
REQ-017 Boundary: complementary operands (b = ~a) SHALL give s=all-ones and eq=0.
REQ-018 Operands SHALL be treated as unsigned bit vectors; no sign extension or width truncation applies.

Reset
REQ-019 While reset is high at a rising clk edge, s SHALL become 0, eq 0, cary 0 and of 0, regardless of a and b.
REQ-020 Reset asserted mid-stream SHALL discard the in-flight result; the first edge with reset low SHALL register the current operands normally.
REQ-021 Reset SHALL have no asynchronous effect; between edges the outputs hold their value.

Structure
REQ-022 A shared package SHALL hold the default width constant (32) and the flag-vector typedef {eq, cary, of} used by all ALU units.
REQ-023 The datapath SHALL be built from one sub-module, or_bit_slice (1-bit OR plus 1-bit XNOR equality term), instantiated WIDTH times with a generate loop.
REQ-024 The top level SHALL AND-reduce the slice equality terms into eq and register all outputs.

Verification
REQ-025 Reset: hold reset high for 2 cycles with a=b=0xFFFFFFFF -> s=0x00000000, eq=0, cary=0, of=0.
REQ-026 Vectors, one per cycle after reset:
- 0x0 and 0x0 -> s=0x00000000, eq=1
- 0xFFFFFFFF and 0xFFFFFFFF -> s=0xFFFFFFFF, eq=1
- 0xFFFF0000 and 0x0000FFFF -> s=0xFFFFFFFF, eq=0
- 0x00000000 and 0xAAAAAAAA -> s=0xAAAAAAAA, eq=0
- 0x55555555 and 0xAAAAAAAA -> s=0xFFFFFFFF, eq=0
- 0xFFFFFFFF and 0x00000000 -> s=0xFFFFFFFF, eq=0
Each response is checked one cycle after its operands are applied.
REQ-027 Latency check: change operands at edge N -> s and eq keep their old values until edge N+1, then show the new result.
REQ-028 Flags: over all vectors, cary=0 and of=0 on every cycle.
REQ-029 Mid-stream reset: assert reset for one cycle during the vector stream.
- Outputs are 0 on the following cycle.
- The next vector's result appears exactly one cycle after reset deasserts.
REQ-030 Random check: 1000 random operand pairs compared against a reference model (s = a|b, eq = (a==b)) with one-cycle delay -> zero mismatches.

Source files
------------

// File: rtl/or_alu_pkg.sv
// ---------------------------------------------------------------------------
// or_alu_pkg
// Shared definitions for the ALU family. Holds the default datapath width and
// the registered flag bundle that every ALU unit presents, so sibling units
// expose identical flag ports whether or not they can set every flag.
// ---------------------------------------------------------------------------
package or_alu_pkg;

  // Default operand/result width for all ALU units
  localparam int unsigned DEFAULT_WIDTH = 32;

  // Flag bundle shared by every ALU unit, ordered {eq, cary, of}
  typedef struct packed {
    logic eq;
    logic cary;
    logic of;
  } alu_flags_t;

  // Flag value used whenever a unit is held in reset
  localparam alu_flags_t FLAGS_CLEAR = '{eq: 1'b0, cary: 1'b0, of: 1'b0};

  // Builds the flag bundle for a purely logical operation: a logical OR can
  // never carry or overflow, so only the equality flag carries information.
  function automatic alu_flags_t logicFlags(input logic eqBit);
    alu_flags_t flags;
    flags      = FLAGS_CLEAR;
    flags.eq   = eqBit;
    return flags;
  endfunction

endpackage

// File: rtl/or_bit_slice.sv
// ---------------------------------------------------------------------------
// or_bit_slice
// One bit of the OR datapath. Produces the OR of the two operand bits and an
// equality term (XNOR) that the top level AND-reduces into the eq flag.
//
// Ports:
//   a_i   input  1  operand A bit
//   b_i   input  1  operand B bit
//   or_o  output 1  a_i | b_i
//   eq_o  output 1  1 when a_i == b_i
// ---------------------------------------------------------------------------
module or_bit_slice (
  input  logic a_i,
  input  logic b_i,
  output logic or_o,
  output logic eq_o
);

  assign or_o = a_i | b_i;
  assign eq_o = ~(a_i ^ b_i);

endmodule

// File: rtl/or_alu.sv
// ---------------------------------------------------------------------------
// or_alu
// Registered bitwise-OR ALU unit with one cycle of latency. A new operand pair
// is accepted on every rising edge and its result appears after that edge.
// All outputs come straight from flops.
//
// Parameters:
//   WIDTH  operand and result width in bits
//
// Ports:
//   clk    input  1      rising-edge clock
//   reset  input  1      synchronous active-high reset, clears all outputs
//   a      input  WIDTH  operand A
//   b      input  WIDTH  operand B
//   s      output WIDTH  registered a | b
//   eq     output 1      registered (a == b)
//   cary   output 1      registered carry, always 0 for OR
//   of     output 1      registered overflow, always 0 for OR
// ---------------------------------------------------------------------------
module or_alu #(
  parameter int unsigned WIDTH = or_alu_pkg::DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] s,
  output logic             eq,
  output logic             cary,
  output logic             of
);

  import or_alu_pkg::*;

  logic [WIDTH-1:0] orVec;
  logic [WIDTH-1:0] eqVec;

  logic [WIDTH-1:0] s_d;
  logic [WIDTH-1:0] s_q;
  alu_flags_t       flags_d;
  alu_flags_t       flags_q;

  // One slice per bit; each slice yields the OR bit and its equality term
  for (genvar i = 0; i < WIDTH; i++) begin : gSlice
    or_bit_slice uSlice (
      .a_i  (a[i]),
      .b_i  (b[i]),
      .or_o (orVec[i]),
      .eq_o (eqVec[i])
    );
  end

  // Next-state: operands are equal only when every bit position matches
  always_comb begin
    s_d     = orVec;
    flags_d = logicFlags(&eqVec);
  end

  // Output registers; reset discards whatever result was in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      s_q     <= '0;
      flags_q <= FLAGS_CLEAR;
    end else begin
      s_q     <= s_d;
      flags_q <= flags_d;
    end
  end

  assign s    = s_q;
  assign eq   = flags_q.eq;
  assign cary = flags_q.cary;
  assign of   = flags_q.of;

endmodule

// File: tb/tb_or_alu.sv
// ---------------------------------------------------------------------------
// tb_or_alu
// Self-checking bench for or_alu (WIDTH = 32). A reference model derived from
// the arithmetic meaning of the unit (result = a | b, eq = a == b, no carry or
// overflow, zeroed by reset) is checked every clock edge, and a set of
// hand-computed vectors pins the model and the one-cycle latency.
// ---------------------------------------------------------------------------
module tb_or_alu;

  localparam int W = 32;

  logic         clk;
  logic         reset;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] s;
  logic         eq;
  logic         cary;
  logic         of;

  int total = 0;
  int bad   = 0;

  // Last literal expectation, used to prove outputs hold between edges
  logic [W-1:0] prevS;
  logic         prevEq;

  or_alu #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .a     (a),
    .b     (b),
    .s     (s),
    .eq    (eq),
    .cary  (cary),
    .of    (of)
  );

  // Free-running clock, 10 ns period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model and per-cycle compare: capture what the DUT sees at the
  // edge, derive the required outputs from the operation's meaning, then
  // check just after the edge once the flops have settled.
  always @(posedge clk) begin
    logic         rSamp;
    logic [W-1:0] aSamp;
    logic [W-1:0] bSamp;
    logic [W-1:0] modelS;
    logic         modelEq;
    rSamp = reset;
    aSamp = a;
    bSamp = b;
    if (rSamp) begin
      modelS  = '0;
      modelEq = 1'b0;
    end else begin
      modelS  = aSamp | bSamp;
      modelEq = (aSamp == bSamp);
    end
    #1;
    total++;
    if (s !== modelS || eq !== modelEq || cary !== 1'b0 || of !== 1'b0) begin
      bad++;
      $display("[TB] FAIL model: s=%h eq=%b cary=%b of=%b, expected s=%h eq=%b cary=0 of=0",
               s, eq, cary, of, modelS, modelEq);
    end
  end

  // Drive a new operand pair (and reset level) away from the active edge
  task automatic applyStimulus(input logic [W-1:0] na, input logic [W-1:0] nb,
                               input logic nreset);
    @(negedge clk);
    a     = na;
    b     = nb;
    reset = nreset;
  endtask

  // Compare the DUT outputs against a literal expectation
  task automatic checkOutput(input string name, input logic [W-1:0] expS,
                             input logic expEq);
    total++;
    if (s !== expS || eq !== expEq || cary !== 1'b0 || of !== 1'b0) begin
      bad++;
      $display("[TB] FAIL %s: s=%h eq=%b cary=%b of=%b, expected s=%h eq=%b cary=0 of=0",
               name, s, eq, cary, of, expS, expEq);
    end
  endtask

  // Drive one vector, check the old result still holds before the edge,
  // then check the new result just after it.
  task automatic stepVector(input string name, input logic [W-1:0] na,
                            input logic [W-1:0] nb, input logic nreset,
                            input logic [W-1:0] expS, input logic expEq);
    applyStimulus(na, nb, nreset);
    #1;
    checkOutput({name, "_hold"}, prevS, prevEq);
    @(posedge clk);
    #2;
    checkOutput(name, expS, expEq);
    prevS  = expS;
    prevEq = expEq;
  endtask

  typedef struct {
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic [W-1:0] vs;
    logic         veq;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1};
    vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1};
    vecs[2] = '{32'hFFFF_0000, 32'h0000_FFFF, 32'hFFFF_FFFF, 1'b0};
    vecs[3] = '{32'h0000_0000, 32'hAAAA_AAAA, 32'hAAAA_AAAA, 1'b0};
    vecs[4] = '{32'h5555_5555, 32'hAAAA_AAAA, 32'hFFFF_FFFF, 1'b0};
    vecs[5] = '{32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0};

    // Reset held for two edges with all-ones operands
    reset = 1'b1;
    a     = '1;
    b     = '1;
    repeat (2) @(posedge clk);
    #2;
    checkOutput("reset", 32'h0000_0000, 1'b0);
    prevS  = '0;
    prevEq = 1'b0;

    // Directed vectors, with a one-cycle reset slipped in before vector 3
    for (int i = 0; i < 6; i++) begin
      if (i == 3) begin
        stepVector("midreset", vecs[i].va, vecs[i].vb, 1'b1, 32'h0000_0000, 1'b0);
      end
      stepVector($sformatf("vec%0d", i), vecs[i].va, vecs[i].vb, 1'b0,
                 vecs[i].vs, vecs[i].veq);
    end

    // Randomized pairs, biased toward equal and complementary operands,
    // with an occasional reset pulse; the model process checks each edge.
    for (int i = 0; i < 1000; i++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      int           kind;
      ra   = $urandom;
      kind = $urandom_range(0, 3);
      case (kind)
        1:       rb = ra;
        2:       rb = ~ra;
        default: rb = $urandom;
      endcase
      applyStimulus(ra, rb, ($urandom_range(0, 49) == 0));
    end

    // Let the last random vector be registered and checked
    applyStimulus('0, '0, 1'b0);
    @(posedge clk);
    #3;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
